// File: rtl/bus_src_encoder.sv
// Registered N:CW bus-source encoder with strict/priority arbitration, idle/conflict flags and sticky error.
// Latency 1 cycle (sample at edge k, outputs valid after edge k); optional conflict_cnt under BUS_ENC_CONFLICT_CNT_EN.
// No back-pressure: one sample per enabled cycle; en=0 freezes outputs while err_clr is still honoured.
module bus_src_encoder #(
  parameter int N    = 24,
  parameter int CW   = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    src_req,
  input  logic            err_clr,
  output logic [CW-1:0]   code,
  output logic            code_vld,
  output logic            idle,
  output logic            conflict,
`ifdef BUS_ENC_CONFLICT_CNT_EN
  output logic [CNTW-1:0] conflict_cnt,
`endif
  output logic            conflict_sticky
);

  if (N < 2 || N > 32 || (2 ** CW) < N) begin : g_bad_param
    $fatal(1, "bus_src_encoder: illegal N/CW combination");
  end

  logic [N-1:0]  req_minus_one;
  logic          req_none;
  logic          req_one;
  logic          req_many;
  logic [CW-1:0] low_idx;
  logic          grant;
  logic          new_conflict;

  // Exactly one bit set iff clearing the lowest set bit leaves nothing.
  assign req_minus_one = src_req - {{(N-1){1'b0}}, 1'b1};
  assign req_none      = (src_req == '0);
  assign req_one       = !req_none && ((src_req & req_minus_one) == '0);
  assign req_many      = !req_none && !req_one;

  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_req[i]) begin
        low_idx = CW'(i);
      end
    end
  end

  assign grant        = req_one || (req_many && mode);
  assign new_conflict = en && req_many;

  always_ff @(posedge clk) begin
    if (clr) begin
      code     <= '0;
      code_vld <= 1'b0;
      idle     <= 1'b1;
      conflict <= 1'b0;
    end else if (en) begin
      if (grant) begin
        code <= low_idx;
      end
      code_vld <= grant;
      idle     <= req_none;
      conflict <= req_many;
    end
  end

  // A conflict on the same edge as err_clr must survive the clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      conflict_sticky <= 1'b0;
    end else begin
      conflict_sticky <= (conflict_sticky && !err_clr) || new_conflict;
    end
  end

`ifdef BUS_ENC_CONFLICT_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      conflict_cnt <= '0;
    end else if (new_conflict) begin
      if (err_clr) begin
        conflict_cnt <= {{(CNTW-1){1'b0}}, 1'b1};
      end else if (conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end else if (err_clr) begin
      conflict_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_bus_src_encoder.sv
// Bench for bus_src_encoder: directed steps plus random traffic against a queue-free behavioural model.
// Checks a 24-source (CNTW=2) and a 32-source instance side by side.
module tb_bus_src_encoder;

  logic        clk = 1'b0;
  logic        clr, en, mode, err_clr;
  logic [31:0] req;
  logic [23:0] req24;

  logic [4:0]  code24, code32;
  logic        vld24, idle24, conf24, st24;
  logic        vld32, idle32, conf32, st32;
`ifdef BUS_ENC_CONFLICT_CNT_EN
  logic [1:0]  cnt24;
  logic [7:0]  cnt32;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  assign req24 = req[23:0];

  bus_src_encoder #(.N(24), .CW(5), .CNTW(2)) dut24 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .src_req(req24), .err_clr(err_clr),
    .code(code24), .code_vld(vld24), .idle(idle24), .conflict(conf24),
`ifdef BUS_ENC_CONFLICT_CNT_EN
    .conflict_cnt(cnt24),
`endif
    .conflict_sticky(st24)
  );

  bus_src_encoder #(.N(32), .CW(5), .CNTW(8)) dut32 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .src_req(req), .err_clr(err_clr),
    .code(code32), .code_vld(vld32), .idle(idle32), .conflict(conf32),
`ifdef BUS_ENC_CONFLICT_CNT_EN
    .conflict_cnt(cnt32),
`endif
    .conflict_sticky(st32)
  );

  typedef struct {
    int code;
    bit vld;
    bit idle;
    bit conf;
    bit sticky;
    int cnt;
  } ms_t;

  ms_t m24, m32;

  // Reference: classify the visible request bits by count, grant by rule table.
  function automatic ms_t model_next(ms_t s, logic [31:0] r, int n, bit md, bit e,
                                     bit ec, bit rst, int cmax);
    ms_t nx;
    int  pc;
    int  low;
    int  base;
    bit  newc;
    nx = s;
    if (rst) begin
      nx.code = 0; nx.vld = 0; nx.idle = 1; nx.conf = 0; nx.sticky = 0; nx.cnt = 0;
      return nx;
    end
    pc  = 0;
    low = -1;
    for (int i = 0; i < n; i++) begin
      if (r[i]) begin
        pc++;
        if (low < 0) low = i;
      end
    end
    if (e) begin
      nx.idle = (pc == 0);
      nx.conf = (pc > 1);
      nx.vld  = (pc == 1) || (pc > 1 && md);
      if (nx.vld) nx.code = low;
    end
    newc      = e && (pc > 1);
    nx.sticky = (s.sticky && !ec) || newc;
    base      = ec ? 0 : s.cnt;
    if (newc && base < cmax) base++;
    nx.cnt = base;
    return nx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("code24", 32'(code24), 32'(m24.code));
    chk("vld24", 32'(vld24), 32'(m24.vld));
    chk("idle24", 32'(idle24), 32'(m24.idle));
    chk("conf24", 32'(conf24), 32'(m24.conf));
    chk("sticky24", 32'(st24), 32'(m24.sticky));
    chk("code32", 32'(code32), 32'(m32.code));
    chk("vld32", 32'(vld32), 32'(m32.vld));
    chk("idle32", 32'(idle32), 32'(m32.idle));
    chk("conf32", 32'(conf32), 32'(m32.conf));
    chk("sticky32", 32'(st32), 32'(m32.sticky));
`ifdef BUS_ENC_CONFLICT_CNT_EN
    chk("cnt24", 32'(cnt24), 32'(m24.cnt));
    chk("cnt32", 32'(cnt32), 32'(m32.cnt));
`endif
  endtask

  task automatic step(input logic [31:0] r, input bit md, input bit e, input bit ec, input bit rst);
    @(negedge clk);
    req = r; mode = md; en = e; err_clr = ec; clr = rst;
    @(posedge clk);
    m24 = model_next(m24, r, 24, md, e, ec, rst, 3);
    m32 = model_next(m32, r, 32, md, e, ec, rst, 255);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    req = '0; mode = 0; en = 0; err_clr = 0; clr = 1;
    m24 = '{default: 0};
    m32 = '{default: 0};

    // Reset with every source requesting.
    step(32'hFFFF_FFFF, 1, 1, 1, 1);
    chk("rst_code", 32'(code24), 32'd0);
    chk("rst_idle", 32'(idle24), 32'd1);

    // Walking one, strict mode.
    for (int i = 0; i < 24; i++) begin
      step(32'd1 << i, 0, 1, 0, 0);
      chk("walk_code", 32'(code24), 32'(i));
    end

    // Idle hold.
    step(32'h0000_0020, 0, 1, 0, 0);
    step(32'h0, 0, 1, 0, 0);
    chk("hold_code", 32'(code24), 32'd5);
    chk("hold_vld", 32'(vld24), 32'd0);

    // Conflict strict, then priority.
    step(32'h0000_0090, 0, 1, 0, 0);
    chk("strict_code", 32'(code24), 32'd5);
    chk("strict_sticky", 32'(st24), 32'd1);
    step(32'h0000_0090, 1, 1, 0, 0);
    chk("prio_code", 32'(code24), 32'd4);
    chk("prio_vld", 32'(vld24), 32'd1);

    // Counter saturation, err_clr alone, err_clr with a conflict.
    step(32'h0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) step(32'h0000_0003, 0, 1, 0, 0);
    step(32'h0, 0, 1, 1, 0);
    chk("errclr_sticky", 32'(st24), 32'd0);
    step(32'h0000_0300, 1, 1, 1, 0);
    chk("same_edge_sticky", 32'(st24), 32'd1);

    // Enable freeze while requests change, err_clr still honoured.
    step(32'h0000_0001, 0, 1, 0, 0);
    step(32'h0000_0006, 1, 0, 0, 0);
    step(32'h0000_0000, 0, 0, 0, 0);
    step(32'h0080_0000, 0, 0, 1, 0);
    chk("freeze_code", 32'(code24), 32'd0);
    step(32'h0080_0000, 0, 1, 0, 0);
    chk("unfreeze_code", 32'(code24), 32'd23);

    // Top source of the 32-wide instance; the 24-wide one never sees it.
    step(32'h8000_0000, 0, 1, 0, 0);
    chk("bit31_code", 32'(code32), 32'd31);
    chk("bit31_idle24", 32'(idle24), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 32'h0;
        1: r = 32'd1 << $urandom_range(0, 31);
        2: r = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      step(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
